pwm_symbol_decoder: RTL and testbench

Parametrised PWM symbol decoder for the SDR receive path. It slices a signed baseband sample stream with a hysteresis threshold derived from a reference amplitude, measures the width of each positive pulse in samples, and quantises that width into a symbol. It is the next generation of `decoder_top`, adding:
- a reset;
- configurable widths and quantisation step;
- hysteresis;
- runt and timeout detection;
- a qualified output strobe.

---
 rtl/pwm_dec_pkg.sv | 8 +
 rtl/pwm_symbol_decoder_if.sv | 15 +
 rtl/pwm_slicer.sv | 15 +
 rtl/pwm_symbol_decoder.sv | 91 +++++++++
 tb/tb_pwm_symbol_decoder.sv | 111 +++++++++++
 5 files changed

// File: rtl/pwm_dec_pkg.sv
// pwm_dec_pkg: shared state/slicer enums and saturation-limit helper for the PWM symbol decoder.
package pwm_dec_pkg;
    typedef enum logic [1:0] {ACQUIRE, LOW, HIGH} state_t;
    typedef enum logic [1:0] {LO, MID, HI} slice_t;
    function automatic logic [31:0] sat_max(input int w);
        return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/pwm_symbol_decoder_if.sv
// pwm_symbol_decoder_if: sample stream in, decoded symbols and error strobes out, plus the live threshold.
interface pwm_symbol_decoder_if #(parameter int DATA_W = 16, parameter int SYM_W = 8);
    logic                     enable_counter;
    logic signed [DATA_W-1:0] ref_in;
    logic signed [DATA_W-1:0] data_in;
    logic signed [DATA_W-1:0] th;
    logic [SYM_W-1:0]         decoded_symbol;
    logic                     symbol_valid;
    logic                     runt_err;
    logic                     timeout_err;
    modport master (output enable_counter, ref_in, data_in,
                    input decoded_symbol, symbol_valid, runt_err, timeout_err, th);
    modport slave (input enable_counter, ref_in, data_in,
                   output decoded_symbol, symbol_valid, runt_err, timeout_err, th);
endinterface

// File: rtl/pwm_slicer.sv
// pwm_slicer: hysteresis slicer; classifies a sample as LO/MID/HI against +/-(ref_in >>> HYST_SHIFT).
module pwm_slicer
    import pwm_dec_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int HYST_SHIFT = 2
) (
    input  logic signed [DATA_W-1:0] data_in,
    input  logic signed [DATA_W-1:0] ref_in,
    output slice_t                   cls,
    output logic signed [DATA_W-1:0] th
);
    assign th  = ref_in[DATA_W-1] ? '0 : ref_in >>> HYST_SHIFT;
    assign cls = (data_in > th) ? HI : (data_in < -th) ? LO : MID;
endmodule

// File: rtl/pwm_symbol_decoder.sv
// pwm_symbol_decoder: measures positive pulse widths and quantises them into symbols.
// Build option PWM_DEC_ROUND_EN rounds the quantisation to the nearest step instead of truncating.
module pwm_symbol_decoder
    import pwm_dec_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 12,
    parameter int SYM_W      = 8,
    parameter int MIN_WIDTH  = 4,
    parameter int STEP_SHIFT = 2,
    parameter int HYST_SHIFT = 2
) (
    input logic clock,
    input logic reset,
    pwm_symbol_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [31:0]      SYM_MAX = sat_max(SYM_W);
    slice_t           cls;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SYM_W-1:0] sym, sym_n;
    logic             valid, valid_n, runt, runt_n, tout, tout_n;
    logic [CNT_W:0]   diff, s;
    pwm_slicer #(.DATA_W(DATA_W), .HYST_SHIFT(HYST_SHIFT)) u_slicer (
        .data_in(bus.data_in),
        .ref_in (bus.ref_in),
        .cls    (cls),
        .th     (bus.th)
    );
    always_comb begin
        diff = {1'b0, cnt} - (CNT_W+1)'(MIN_WIDTH);
`ifdef PWM_DEC_ROUND_EN
        s = (diff + (CNT_W+1)'((2**STEP_SHIFT) / 2)) >> STEP_SHIFT;
`else
        s = diff >> STEP_SHIFT;
`endif
    end
    // A crossing out of LOW or HIGH restarts the count; otherwise count or time out at saturation.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sym_n   = sym;
        valid_n = 1'b0;
        runt_n  = 1'b0;
        tout_n  = 1'b0;
        if (bus.enable_counter) begin
            if (state == ACQUIRE) begin
                if (cls == LO) begin
                    state_n = LOW;
                    cnt_n   = CNT_W'(1);
                end
            end else if ((state == LOW) ? (cls == HI) : (cls == LO)) begin
                state_n = (state == LOW) ? HIGH : LOW;
                cnt_n   = CNT_W'(1);
                if (state != LOW) begin
                    runt_n  = cnt < CNT_W'(MIN_WIDTH);
                    valid_n = !runt_n;
                    sym_n   = runt_n ? sym : (32'(s) > SYM_MAX) ? SYM_W'(SYM_MAX) : SYM_W'(s);
                end
            end else if (cnt == CNT_MAX) begin
                state_n = ACQUIRE;
                cnt_n   = '0;
                tout_n  = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACQUIRE;
            cnt   <= '0;
            sym   <= '0;
            valid <= 1'b0;
            runt  <= 1'b0;
            tout  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sym   <= sym_n;
            valid <= valid_n;
            runt  <= runt_n;
            tout  <= tout_n;
        end
    end
    assign bus.decoded_symbol = sym;
    assign bus.symbol_valid   = valid;
    assign bus.runt_err       = runt;
    assign bus.timeout_err    = tout;
endmodule

// File: tb/tb_pwm_symbol_decoder.sv
// tb_pwm_symbol_decoder: directed scenarios with a per-sample expected-outcome queue.
module tb_pwm_symbol_decoder;
    typedef enum {K_NONE, K_SYM, K_RUNT, K_TO} kind_t;
    typedef struct {kind_t k; logic [7:0] sym;} exp_t;
`ifdef PWM_DEC_ROUND_EN
    localparam logic [7:0] SYM_W22 = 8'd5;
`else
    localparam logic [7:0] SYM_W22 = 8'd4;
`endif
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    exp_t       q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] cur_sym = 8'd0;
    always #5 clock = ~clock;
    pwm_symbol_decoder_if bus ();
    pwm_symbol_decoder dut (.clock(clock), .reset(reset), .bus(bus));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic signed [15:0] d, input logic en, input kind_t k);
        exp_t e;
        bus.data_in = d;
        bus.enable_counter = en;
        e.k = k;
        e.sym = cur_sym;
        q.push_back(e);
        @(posedge clock);
        #1;
        e = q.pop_front();
        check("symbol_valid", {31'd0, bus.symbol_valid}, {31'd0, e.k == K_SYM});
        check("runt_err", {31'd0, bus.runt_err}, {31'd0, e.k == K_RUNT});
        check("timeout_err", {31'd0, bus.timeout_err}, {31'd0, e.k == K_TO});
        check("decoded_symbol", {24'd0, bus.decoded_symbol}, {24'd0, e.sym});
    endtask
    task automatic run(input logic signed [15:0] d, input int n);
        repeat (n) step(d, 1'b1, K_NONE);
    endtask
    task automatic emit(input kind_t k, input logic [7:0] s);
        if (k == K_SYM) cur_sym = s;
        step(-16'sd100, 1'b1, k);
    endtask
    initial begin
        bus.enable_counter = 1'b1;
        bus.data_in = '0;
        bus.ref_in = -16'sd8;
        #1;
        check("th_negative_ref", 32'(bus.th), 32'd0);
        bus.ref_in = 16'sd95;
        #1;
        check("th_ref95", 32'(bus.th), 32'd23);
        step(16'sd0, 1'b1, K_NONE);
        step(-16'sd100, 1'b1, K_NONE);
        reset = 1'b0;
        // nominal width 20
        run(16'sd100, 3);
        run(-16'sd50, 5);
        run(16'sd100, 20);
        emit(K_SYM, 8'd4);
        // width 22 truncates or rounds depending on build
        run(-16'sd50, 3);
        run(16'sd100, 22);
        emit(K_SYM, SYM_W22);
        // inside the hysteresis band nothing happens
        for (int i = 0; i < 10; i++) step((i % 2) ? 16'sd20 : -16'sd20, 1'b1, K_NONE);
        run(16'sd100, 3);
        emit(K_RUNT, cur_sym);
        // shortest legal pulse
        run(16'sd100, 4);
        emit(K_SYM, 8'd0);
        // stall mid-pulse with a LO sample presented while disabled
        run(-16'sd50, 2);
        run(16'sd100, 10);
        repeat (7) step(-16'sd100, 1'b0, K_NONE);
        run(16'sd100, 10);
        emit(K_SYM, 8'd4);
        // symbol saturation
        run(-16'sd50, 2);
        run(16'sd100, 1204);
        emit(K_SYM, 8'd255);
        // counter timeout then re-acquire
        run(-16'sd50, 2);
        run(16'sd100, 4095);
        step(16'sd100, 1'b1, K_TO);
        run(16'sd100, 3);
        step(-16'sd100, 1'b1, K_NONE);
        run(16'sd100, 12);
        emit(K_SYM, 8'd2);
        // reset mid-pulse discards it
        run(-16'sd50, 2);
        run(16'sd100, 6);
        reset = 1'b1;
        cur_sym = 8'd0;
        step(16'sd100, 1'b1, K_NONE);
        reset = 1'b0;
        run(16'sd100, 5);
        step(-16'sd100, 1'b1, K_NONE);
        run(-16'sd50, 1);
        run(16'sd100, 12);
        emit(K_SYM, 8'd2);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
